// File: rtl/pulse_cmd_parser.sv
// Command-frame decoder for the pulse generator: builds staged timing values
// from UART bytes and publishes them all at once on commit, answering ACK/NAK.
module pulse_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] period,
  output logic [15:0] p1width,
  output logic [15:0] delay,
  output logic [15:0] p2width,
  output logic [15:0] nut_del,
  output logic [7:0]  nut_wid,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic [7:0]  cpmg,
  output logic        block,
  output logic        rx_done,
  output logic        cmd_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] D_PERIOD  = 32'h0001_0000;
  localparam logic [15:0] D_P1WIDTH = 16'd30;
  localparam logic [15:0] D_DELAY   = 16'd200;
  localparam logic [15:0] D_P2WIDTH = 16'd60;
  localparam logic [15:0] D_NUT_DEL = 16'd100;
  localparam logic [7:0]  D_NUT_WID = 8'd100;
  localparam logic [7:0]  D_PBLOCK  = 8'd50;
  localparam logic [15:0] D_PB_OFF  = 16'd100;
  localparam logic [7:0]  D_CPMG    = 8'd4;
  localparam logic        D_BLOCK   = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EXEC} state_t;

  state_t          state;
  logic [7:0]      opcode;
  logic [2:0]      remaining;
  logic [23:0]     shift;
  logic [TW-1:0]   tmo_cnt;

  logic [31:0] sh_period;
  logic [15:0] sh_p1width, sh_delay, sh_p2width, sh_nut_del, sh_pb_off;
  logic [7:0]  sh_nut_wid, sh_pblock, sh_cpmg;
  logic        sh_block;

  logic        exec_go;
  logic [7:0]  exec_op;
  logic [31:0] exec_val;

  function automatic logic [2:0] op_len(input logic [7:0] op);
    case (op)
      8'h01:                      op_len = 3'd4;
      8'h02, 8'h03, 8'h04, 8'h05,
      8'h08:                      op_len = 3'd2;
      8'h06, 8'h07, 8'h09, 8'h0A: op_len = 3'd1;
      default:                    op_len = 3'd0;
    endcase
  endfunction

  function automatic logic op_known(input logic [7:0] op);
    op_known = (op >= 8'h01 && op <= 8'h0A) || op == 8'h10 || op == 8'h11;
  endfunction

  // The frame's action is applied on the edge that enters EXEC, so the EXEC
  // cycle already shows the result (one-cycle latency from the last byte).
  always_comb begin
    exec_go  = 1'b0;
    exec_op  = rx_data;
    exec_val = {shift, rx_data};
    if (rx_valid) begin
      if (state == S_DATA) begin
        exec_op = opcode;
        exec_go = (remaining == 3'd1);
      end else begin
        exec_go = op_known(rx_data) && (op_len(rx_data) == 3'd0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      opcode     <= 8'h00;
      remaining  <= 3'd0;
      shift      <= 24'h0;
      tmo_cnt    <= '0;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      rx_done    <= 1'b0;
      cmd_err    <= 1'b0;
      sh_period  <= D_PERIOD;   period          <= D_PERIOD;
      sh_p1width <= D_P1WIDTH;  p1width         <= D_P1WIDTH;
      sh_delay   <= D_DELAY;    delay           <= D_DELAY;
      sh_p2width <= D_P2WIDTH;  p2width         <= D_P2WIDTH;
      sh_nut_del <= D_NUT_DEL;  nut_del         <= D_NUT_DEL;
      sh_nut_wid <= D_NUT_WID;  nut_wid         <= D_NUT_WID;
      sh_pblock  <= D_PBLOCK;   pulse_block     <= D_PBLOCK;
      sh_pb_off  <= D_PB_OFF;   pulse_block_off <= D_PB_OFF;
      sh_cpmg    <= D_CPMG;     cpmg            <= D_CPMG;
      sh_block   <= D_BLOCK;    block           <= D_BLOCK;
    end else begin
      rx_done <= 1'b0;
      cmd_err <= 1'b0;
      if (tx_valid && tx_ready) tx_valid <= 1'b0;

      case (state)
        S_IDLE, S_EXEC: begin
          state   <= S_IDLE;
          tmo_cnt <= '0;
          if (rx_valid) begin
            if (!op_known(rx_data)) begin
              cmd_err  <= 1'b1;
              tx_valid <= 1'b1;
              tx_data  <= NAK_BYTE;
            end else if (op_len(rx_data) != 3'd0) begin
              opcode    <= rx_data;
              remaining <= op_len(rx_data);
              shift     <= 24'h0;
              state     <= S_DATA;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            shift     <= exec_val[23:0];
            remaining <= remaining - 3'd1;
            tmo_cnt   <= '0;
            if (remaining == 3'd1) state <= S_EXEC;
          end else if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
            tmo_cnt  <= '0;
            cmd_err  <= 1'b1;
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
            state    <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      if (exec_go) begin
        case (exec_op)
          8'h01: sh_period  <= exec_val;
          8'h02: sh_p1width <= exec_val[15:0];
          8'h03: sh_delay   <= exec_val[15:0];
          8'h04: sh_p2width <= exec_val[15:0];
          8'h05: sh_nut_del <= exec_val[15:0];
          8'h06: sh_nut_wid <= exec_val[7:0];
          8'h07: sh_pblock  <= exec_val[7:0];
          8'h08: sh_pb_off  <= exec_val[15:0];
          8'h09: sh_cpmg    <= exec_val[7:0];
          8'h0A: sh_block   <= exec_val[0];
          8'h10: begin
            period          <= sh_period;
            p1width         <= sh_p1width;
            delay           <= sh_delay;
            p2width         <= sh_p2width;
            nut_del         <= sh_nut_del;
            nut_wid         <= sh_nut_wid;
            pulse_block     <= sh_pblock;
            pulse_block_off <= sh_pb_off;
            cpmg            <= sh_cpmg;
            block           <= sh_block;
            rx_done         <= 1'b1;
            tx_valid        <= 1'b1;
            tx_data         <= ACK_BYTE;
          end
          8'h11: begin
            sh_period  <= D_PERIOD;
            sh_p1width <= D_P1WIDTH;
            sh_delay   <= D_DELAY;
            sh_p2width <= D_P2WIDTH;
            sh_nut_del <= D_NUT_DEL;
            sh_nut_wid <= D_NUT_WID;
            sh_pblock  <= D_PBLOCK;
            sh_pb_off  <= D_PB_OFF;
            sh_cpmg    <= D_CPMG;
            sh_block   <= D_BLOCK;
            tx_valid   <= 1'b1;
            tx_data    <= ACK_BYTE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pulse_cmd_parser.sv
// Bench for pulse_cmd_parser: directed scenarios plus random frames checked
// against a register-array model of the shadow/live copies.
module tb_pulse_cmd_parser;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] period;
  logic [15:0] p1width, delay, p2width, nut_del, pulse_block_off;
  logic [7:0]  nut_wid, pulse_block, cpmg;
  logic        block, rx_done, cmd_err;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sh [1:10];
  logic [31:0] lv [1:10];

  pulse_cmd_parser #(.TIMEOUT_CYCLES(TO), .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
    .nut_del(nut_del), .nut_wid(nut_wid), .pulse_block(pulse_block),
    .pulse_block_off(pulse_block_off), .cpmg(cpmg), .block(block),
    .rx_done(rx_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int width_of(input int i);
    case (i)
      1: width_of = 32;
      6, 7, 9: width_of = 8;
      10: width_of = 1;
      default: width_of = 16;
    endcase
  endfunction

  function automatic int nbytes(input int i);
    nbytes = (i == 10) ? 1 : width_of(i) / 8;
  endfunction

  function automatic logic [31:0] default_of(input int i);
    case (i)
      1: default_of = 32'h0001_0000;
      2: default_of = 30;
      3: default_of = 200;
      4: default_of = 60;
      5: default_of = 100;
      6: default_of = 100;
      7: default_of = 50;
      8: default_of = 100;
      9: default_of = 4;
      default: default_of = 1;
    endcase
  endfunction

  function automatic bit is_known(input logic [7:0] op);
    is_known = (op >= 8'h01 && op <= 8'h0A) || op == 8'h10 || op == 8'h11;
  endfunction

  task automatic m_reset();
    for (int i = 1; i <= 10; i++) begin sh[i] = default_of(i); lv[i] = default_of(i); end
  endtask

  task automatic m_write(input int i, input logic [31:0] v);
    logic [63:0] mask;
    mask = (64'd1 << width_of(i)) - 64'd1;
    sh[i] = v & mask[31:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_live(input string ctx);
    chk({ctx, ".period"}, period, lv[1]);
    chk({ctx, ".p1width"}, 32'(p1width), lv[2]);
    chk({ctx, ".delay"}, 32'(delay), lv[3]);
    chk({ctx, ".p2width"}, 32'(p2width), lv[4]);
    chk({ctx, ".nut_del"}, 32'(nut_del), lv[5]);
    chk({ctx, ".nut_wid"}, 32'(nut_wid), lv[6]);
    chk({ctx, ".pulse_block"}, 32'(pulse_block), lv[7]);
    chk({ctx, ".pulse_block_off"}, 32'(pulse_block_off), lv[8]);
    chk({ctx, ".cpmg"}, 32'(cpmg), lv[9]);
    chk({ctx, ".block"}, 32'(block), lv[10]);
  endtask

  // Called at a falling edge; returns at the next falling edge, one cycle on.
  task automatic put(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_write(input int i, input logic [31:0] v, input int max_gap);
    put(8'(i));
    for (int k = nbytes(i) - 1; k >= 0; k--) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      put(v[8*k +: 8]);
    end
    m_write(i, v);
    check_live("after_write");
    chk("write_no_rx_done", 32'(rx_done), 0);
  endtask

  task automatic do_commit(input string ctx);
    put(8'h10);
    for (int i = 1; i <= 10; i++) lv[i] = sh[i];
    check_live(ctx);
    chk({ctx, ".rx_done"}, 32'(rx_done), 1);
    chk({ctx, ".tx_valid"}, 32'(tx_valid), 1);
    chk({ctx, ".tx_data"}, 32'(tx_data), 32'h06);
    @(negedge clk);
    chk({ctx, ".rx_done_drop"}, 32'(rx_done), 0);
  endtask

  task automatic send_unknown(input logic [7:0] op);
    put(op);
    chk("unk.cmd_err", 32'(cmd_err), 1);
    chk("unk.tx_valid", 32'(tx_valid), 1);
    chk("unk.tx_data", 32'(tx_data), 32'h15);
    @(negedge clk);
    chk("unk.cmd_err_drop", 32'(cmd_err), 0);
  endtask

  initial begin
    int found, cnt;
    logic [7:0] nak;
    logic [7:0] op;
    logic [31:0] v;
    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    m_reset();
    check_live("reset");
    chk("reset.rx_done", 32'(rx_done), 0);
    chk("reset.tx_valid", 32'(tx_valid), 0);
    chk("reset.tx_data", 32'(tx_data), 0);
    chk("reset.cmd_err", 32'(cmd_err), 0);
    resetn = 1'b1;
    @(negedge clk);

    // period write, commit with the response held pending
    send_write(1, 32'h0002_0000, 0);
    do_commit("commit_period");
    repeat (3) @(negedge clk);
    chk("ack_held.tx_valid", 32'(tx_valid), 1);
    chk("ack_held.tx_data", 32'(tx_data), 32'h06);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("ack_accepted", 32'(tx_valid), 0);

    // shadow write must not touch live until commit
    send_write(3, 32'h01F4, 0);
    repeat (2) @(negedge clk);
    chk("delay_uncommitted", 32'(delay), 200);
    do_commit("commit_delay");

    // timeout of a partial frame
    put(8'h02);
    put(8'h00);
    found = 0; cnt = 0; nak = 8'h00;
    for (int i = 1; i <= TO + 10 && found == 0; i++) begin
      @(negedge clk);
      if (cmd_err === 1'b1) begin found = 1; cnt = i; nak = tx_data; end
    end
    chk("timeout.seen", 32'(found), 1);
    chk("timeout.window", 32'(cnt >= TO - 1 && cnt <= TO + 2), 1);
    chk("timeout.nak", 32'(nak), 32'h15);
    do_commit("commit_after_timeout");
    send_write(2, 32'h002D, 0);
    do_commit("commit_p1width");
    chk("p1width_45", 32'(p1width), 45);

    // unknown opcode, block bit handling
    send_unknown(8'h7F);
    send_write(10, 32'h00FF, 0);
    do_commit("commit_block1");
    chk("block_ff", 32'(block), 1);
    send_write(10, 32'h0000, 0);
    do_commit("commit_block0");
    chk("block_00", 32'(block), 0);

    // reset mid-frame discards the frame and restores defaults
    send_write(9, 32'h07, 0);
    do_commit("commit_cpmg7");
    put(8'h09);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_reset();
    do_commit("commit_after_reset");
    chk("cpmg_default", 32'(cpmg), 4);

    // two commits with TX stalled: a single pending ACK
    tx_ready = 1'b0;
    do_commit("stall_a");
    do_commit("stall_b");
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stall.accepted", 32'(tx_valid), 0);
    repeat (3) @(negedge clk);
    chk("stall.single", 32'(tx_valid), 0);

    // random frames
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'hFFFF_FFFF;
            default: v = $urandom;
          endcase
          send_write($urandom_range(1, 10), v, $urandom_range(0, 4));
        end
        6, 7: do_commit("rand_commit");
        8: begin
          put(8'h11);
          for (int i = 1; i <= 10; i++) sh[i] = default_of(i);
          chk("defaults.tx_data", 32'(tx_data), 32'h06);
          chk("defaults.tx_valid", 32'(tx_valid), 1);
          check_live("defaults");
        end
        default: begin
          op = 8'($urandom);
          while (is_known(op)) op = 8'($urandom);
          send_unknown(op);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    do_commit("final_commit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
